// File: rtl/ahbl_boot_copier.sv
// AHB-Lite boot copier: moves a fixed ROM image into RAM after reset
// and holds the CPU in reset until the first copy has finished.
module ahbl_boot_copier #(
    parameter logic [31:0] SRC_ADDR   = 32'h0000_0000,
    parameter logic [31:0] DST_ADDR   = 32'h2000_0000,
    parameter int          WORDS      = 1024,
    parameter bit          AUTO_START = 1'b1
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    output logic [31:0] HADDR,
    output logic [1:0]  HTRANS,
    output logic [2:0]  HSIZE,
    output logic        HWRITE,
    output logic [31:0] HWDATA,
    input  logic [31:0] HRDATA,
    input  logic        HREADY,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic        cpu_rst_n
);

    localparam int            CW     = (WORDS > 0) ? $clog2(WORDS + 1) : 1;
    localparam logic [CW-1:0] LAST   = CW'(WORDS);
    localparam logic [1:0]    T_IDLE = 2'b00;
    localparam logic [1:0]    T_NSEQ = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_A,
        S_RD_D,
        S_WR_A,
        S_WR_D
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nx;
    logic [31:0]   rd_ptr;
    logic [31:0]   wr_ptr;
    logic          first;
    logic          go;

    // first is high only for the cycle right after reset release
    assign go     = start || (AUTO_START && first);
    assign cnt_nx = cnt + CW'(1);
    assign HSIZE  = 3'b010;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state     <= S_IDLE;
            HADDR     <= 32'h0;
            HTRANS    <= T_IDLE;
            HWRITE    <= 1'b0;
            HWDATA    <= 32'h0;
            cnt       <= '0;
            rd_ptr    <= 32'h0;
            wr_ptr    <= 32'h0;
            first     <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
            cpu_rst_n <= 1'b0;
        end else begin
            first <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (go) begin
                        done <= (WORDS == 0);
                        if (WORDS == 0) begin
                            cpu_rst_n <= 1'b1;
                        end else begin
                            state  <= S_RD_A;
                            busy   <= 1'b1;
                            cnt    <= '0;
                            rd_ptr <= SRC_ADDR;
                            wr_ptr <= DST_ADDR;
                            HADDR  <= SRC_ADDR;
                            HTRANS <= T_NSEQ;
                            HWRITE <= 1'b0;
                        end
                    end
                end
                S_RD_A: begin
                    if (HREADY) begin
                        state  <= S_RD_D;
                        HTRANS <= T_IDLE;
                    end
                end
                S_RD_D: begin
                    if (HREADY) begin
                        state  <= S_WR_A;
                        HWDATA <= HRDATA;
                        HADDR  <= wr_ptr;
                        HTRANS <= T_NSEQ;
                        HWRITE <= 1'b1;
                    end
                end
                S_WR_A: begin
                    if (HREADY) begin
                        state  <= S_WR_D;
                        HTRANS <= T_IDLE;
                        HWRITE <= 1'b0;
                    end
                end
                S_WR_D: begin
                    if (HREADY) begin
                        rd_ptr <= rd_ptr + 32'd4;
                        wr_ptr <= wr_ptr + 32'd4;
                        cnt    <= cnt_nx;
                        if (cnt_nx == LAST) begin
                            state     <= S_IDLE;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                            cpu_rst_n <= 1'b1;
                        end else begin
                            state  <= S_RD_A;
                            HADDR  <= rd_ptr + 32'd4;
                            HTRANS <= T_NSEQ;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ahbl_boot_copier.sv
// Bench for ahbl_boot_copier: three instances (auto 4 words, manual
// 4 words, zero words) against simple ROM/RAM slave models.
module tb_ahbl_boot_copier;

    localparam logic [31:0] SRC  = 32'h0000_0000;
    localparam logic [31:0] DST  = 32'h2000_0000;
    localparam logic [1:0]  NSEQ = 2'b10;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rstn   [3];
    logic hready [3];
    logic start  [3];

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        hrdy;
        logic        stv;
        logic [1:0]  trans;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wd;
        logic        bsy;
        logic        dn;
        logic        crst;
        logic        ck_a;
        logic        ck_d;
    } vec_t;

    for (genvar g = 0; g < 3; g++) begin : u
        logic [31:0] haddr, hwdata, hrdata;
        logic [1:0]  htrans;
        logic [2:0]  hsize;
        logic        hwrite, busy, done, cpu_rst_n;
        logic [31:0] rom [4];
        logic [31:0] ram [4];
        logic        pv = 1'b0;
        logic        pw = 1'b0;
        logic [31:0] pa = 32'h0;
        logic [31:0] lg_a [64];
        logic        lg_w [64];
        int          n = 0;

        ahbl_boot_copier #(
            .SRC_ADDR  (SRC),
            .DST_ADDR  (DST),
            .WORDS     ((g == 2) ? 0 : 4),
            .AUTO_START((g == 1) ? 1'b0 : 1'b1)
        ) dut (
            .HCLK     (clk),
            .HRESETn  (rstn[g]),
            .HADDR    (haddr),
            .HTRANS   (htrans),
            .HSIZE    (hsize),
            .HWRITE   (hwrite),
            .HWDATA   (hwdata),
            .HRDATA   (hrdata),
            .HREADY   (hready[g]),
            .start    (start[g]),
            .busy     (busy),
            .done     (done),
            .cpu_rst_n(cpu_rst_n)
        );

        assign hrdata = (pv && !pw) ? rom[pa[3:2]] : 32'hDEAD_BEEF;

        always @(posedge clk or negedge rstn[g]) begin
            if (!rstn[g]) begin
                pv <= 1'b0;
            end else if (hready[g]) begin
                if (pv && pw) ram[pa[3:2]] <= hwdata;
                pv <= (htrans == NSEQ);
                pa <= haddr;
                pw <= hwrite;
                if (htrans == NSEQ && n < 64) begin
                    lg_a[n] <= haddr;
                    lg_w[n] <= hwrite;
                    n <= n + 1;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // expected bus order for one copy: read src word k, then write dst word k
    task automatic chk_seq(input string nm, input logic [31:0] la [64],
                           input logic lw [64], input int base,
                           input int nxt);
        chk({nm, " xfer count"}, 32'(nxt - base), 32'd8);
        for (int k = 0; k < 4; k++) begin
            if (base + 2 * k + 1 < 64) begin
                chk($sformatf("%s rd addr %0d", nm, k),
                    la[base + 2 * k], SRC + 32'(4 * k));
                chk($sformatf("%s rd dir %0d", nm, k),
                    32'(lw[base + 2 * k]), 32'd0);
                chk($sformatf("%s wr addr %0d", nm, k),
                    la[base + 2 * k + 1], DST + 32'(4 * k));
                chk($sformatf("%s wr dir %0d", nm, k),
                    32'(lw[base + 2 * k + 1]), 32'd1);
            end
        end
    endtask

    task automatic chk_ram(input string nm, input logic [31:0] r [4],
                           input logic [31:0] e [4]);
        for (int k = 0; k < 4; k++)
            chk($sformatf("%s ram[%0d]", nm, k), r[k], e[k]);
    endtask

    task automatic chk_rst0(input string nm);
        chk({nm, " haddr"},  u[0].haddr, 32'h0);
        chk({nm, " htrans"}, 32'(u[0].htrans), 32'h0);
        chk({nm, " hwrite"}, 32'(u[0].hwrite), 32'h0);
        chk({nm, " hsize"},  32'(u[0].hsize), 32'h2);
        chk({nm, " hwdata"}, u[0].hwdata, 32'h0);
        chk({nm, " busy"},   32'(u[0].busy), 32'h0);
        chk({nm, " done"},   32'(u[0].done), 32'h0);
        chk({nm, " cpu_rst_n"}, 32'(u[0].cpu_rst_n), 32'h0);
    endtask

    initial begin
        vec_t        tbl [1:17];
        logic [31:0] img [4];
        int          p, k, e, bc, sc, base;
        logic        hr, seen_low;

        img = '{32'h11, 32'h22, 32'h33, 32'h44};
        for (int n = 1; n <= 17; n++) begin
            p = (n - 1) % 4;
            k = (n - 1) / 4;
            tbl[n] = '{1'b1, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0,
                       1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
            if (n == 17) begin
                tbl[n].bsy  = 1'b0;
                tbl[n].dn   = 1'b1;
                tbl[n].crst = 1'b1;
            end else if (p == 0) begin
                tbl[n].trans = NSEQ;
                tbl[n].addr  = SRC + 32'(4 * k);
                tbl[n].ck_a  = 1'b1;
            end else if (p == 2) begin
                tbl[n].trans = NSEQ;
                tbl[n].wr    = 1'b1;
                tbl[n].addr  = DST + 32'(4 * k);
                tbl[n].ck_a  = 1'b1;
            end else if (p == 3) begin
                tbl[n].wd   = img[k];
                tbl[n].ck_d = 1'b1;
            end
        end

        for (int i = 0; i < 3; i++) begin
            rstn[i]   = 1'b1;
            hready[i] = 1'b1;
            start[i]  = 1'b0;
        end
        for (int i = 0; i < 4; i++) begin
            u[0].rom[i] = img[i];
            u[1].rom[i] = $urandom;
            u[2].rom[i] = $urandom;
        end
        #1;
        for (int i = 0; i < 3; i++) rstn[i] = 1'b0;
        #1;
        chk_rst0("reset");
        chk("reset z done", 32'(u[2].done), 32'h0);
        chk("reset z cpu_rst_n", 32'(u[2].cpu_rst_n), 32'h0);
        #5;
        for (int i = 0; i < 3; i++) rstn[i] = 1'b1;

        // cycle-by-cycle zero-wait copy on the auto-start instance
        for (int n = 1; n <= 17; n++) begin
            hready[0] = tbl[n].hrdy;
            start[0]  = tbl[n].stv;
            step();
            chk($sformatf("row%0d htrans", n), 32'(u[0].htrans),
                32'(tbl[n].trans));
            chk($sformatf("row%0d busy", n), 32'(u[0].busy),
                32'(tbl[n].bsy));
            chk($sformatf("row%0d done", n), 32'(u[0].done),
                32'(tbl[n].dn));
            chk($sformatf("row%0d cpu_rst_n", n), 32'(u[0].cpu_rst_n),
                32'(tbl[n].crst));
            if (tbl[n].ck_a) begin
                chk($sformatf("row%0d haddr", n), u[0].haddr, tbl[n].addr);
                chk($sformatf("row%0d hwrite", n), 32'(u[0].hwrite),
                    32'(tbl[n].wr));
            end
            if (tbl[n].ck_d)
                chk($sformatf("row%0d hwdata", n), u[0].hwdata, tbl[n].wd);
            if (n == 1) begin
                chk("zero done", 32'(u[2].done), 32'h1);
                chk("zero cpu_rst_n", 32'(u[2].cpu_rst_n), 32'h1);
                chk("zero busy", 32'(u[2].busy), 32'h0);
            end
        end
        chk_ram("auto", u[0].ram, img);
        chk_seq("auto", u[0].lg_a, u[0].lg_w, 0, u[0].n);
        chk("manual idle xfers", 32'(u[1].n), 32'h0);
        chk("manual cpu held", 32'(u[1].cpu_rst_n), 32'h0);

        // manual start, ignored second start, 3-cycle stall in word 1 RD_D
        step();
        start[1] = 1'b1;
        step();
        start[1] = 1'b0;
        chk("man accept htrans", 32'(u[1].htrans), 32'(NSEQ));
        chk("man accept haddr", u[1].haddr, SRC);
        chk("man accept busy", 32'(u[1].busy), 32'h1);
        step();
        step();
        start[1] = 1'b1;
        step();
        start[1] = 1'b0;
        step();
        step();
        hready[1] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("stall%0d htrans", i), 32'(u[1].htrans), 32'h0);
            chk($sformatf("stall%0d haddr", i), u[1].haddr, SRC + 32'd4);
        end
        hready[1] = 1'b1;
        e = 8;
        while (!u[1].done && e < 60) begin
            step();
            e++;
        end
        chk("man done edge", 32'(e), 32'd19);
        chk("man cpu_rst_n", 32'(u[1].cpu_rst_n), 32'h1);
        chk_ram("man", u[1].ram, u[1].rom);
        for (int i = 0; i < 6; i++) step();
        chk_seq("man", u[1].lg_a, u[1].lg_w, 0, u[1].n);

        // re-run with random data and random wait states
        for (int i = 0; i < 4; i++) begin
            img[i] = $urandom;
            u[0].rom[i] = img[i];
        end
        base = u[0].n;
        start[0] = 1'b1;
        step();
        start[0] = 1'b0;
        chk("rerun done clr", 32'(u[0].done), 32'h0);
        chk("rerun busy", 32'(u[0].busy), 32'h1);
        bc = 0;
        sc = 0;
        seen_low = 1'b0;
        while (u[0].busy && bc < 400) begin
            bc++;
            hr = ($urandom_range(0, 2) != 0);
            if (!hr) sc++;
            hready[0] = hr;
            step();
            if (!u[0].cpu_rst_n) seen_low = 1'b1;
        end
        hready[0] = 1'b1;
        chk("rerun cycles", 32'(bc), 32'(16 + sc));
        chk("rerun done", 32'(u[0].done), 32'h1);
        chk("rerun cpu_rst_n low", 32'(seen_low), 32'h0);
        chk_ram("rerun", u[0].ram, img);
        chk_seq("rerun", u[0].lg_a, u[0].lg_w, base, u[0].n);

        // reset pulse in word 2, auto restart from word 0
        for (int i = 0; i < 4; i++) begin
            img[i] = $urandom;
            u[0].rom[i] = img[i];
        end
        start[0] = 1'b1;
        step();
        start[0] = 1'b0;
        for (int i = 0; i < 9; i++) step();
        #2;
        rstn[0] = 1'b0;
        #1;
        chk_rst0("midrst");
        step();
        chk("midrst held htrans", 32'(u[0].htrans), 32'h0);
        #2;
        rstn[0] = 1'b1;
        base = u[0].n;
        step();
        chk("restart htrans", 32'(u[0].htrans), 32'(NSEQ));
        chk("restart haddr", u[0].haddr, SRC);
        chk("restart cpu_rst_n", 32'(u[0].cpu_rst_n), 32'h0);
        e = 1;
        while (!u[0].done && e < 60) begin
            step();
            e++;
        end
        chk("restart done edge", 32'(e), 32'd17);
        chk_ram("restart", u[0].ram, img);
        chk_seq("restart", u[0].lg_a, u[0].lg_w, base, u[0].n);

        // zero-word instance re-run: completes on the accepting edge
        start[2] = 1'b1;
        step();
        start[2] = 1'b0;
        chk("zero rerun done", 32'(u[2].done), 32'h1);
        chk("zero rerun busy", 32'(u[2].busy), 32'h0);
        step();
        chk("zero xfers", 32'(u[2].n), 32'h0);
        chk("zero cpu_rst_n", 32'(u[2].cpu_rst_n), 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
